weighted_round_robin_arbiter: RTL and testbench

- Parametrised successor to the team's plain round-robin arbiter.
- Arbitrates REQUIRE_NUM requesters onto one shared resource, one-hot grant.
- Each requester has a runtime weight: once granted, it may keep the grant for up to that many consecutive cycles before rotation.
- Sits in front of shared buses, DMA channels and memory ports where bandwidth shares must be unequal.

---
 rtl/weighted_round_robin_arbiter.sv | 159 +++++++++++++++
 tb/tb_weighted_round_robin_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/weighted_round_robin_arbiter.sv
// Weighted round-robin arbiter.
// Grants one of REQUIRE_NUM requesters at a time (registered one-hot grant).
// A granted requester may keep the grant for up to its latched weight
// (0 counts as 1) in consecutive cycles before the grant rotates onward.
// Optional feature macro: WRR_HOLD_EN adds a hold_i input that freezes
// the arbiter state (grant, credit counter, grant_last_o) while asserted.

module weighted_round_robin_arbiter #(
  parameter int REQUIRE_NUM = 4,
  parameter int WEIGHT_W    = 4,
  localparam int ID_W       = $clog2(REQUIRE_NUM)
) (
  input  logic                            sys_clk_i,
  input  logic                            rst_n_i,
  input  logic [REQUIRE_NUM-1:0]          request_i,
  input  logic [REQUIRE_NUM*WEIGHT_W-1:0] weight_i,
`ifdef WRR_HOLD_EN
  input  logic                            hold_i,
`endif
  output logic [REQUIRE_NUM-1:0]          respond_o,
  output logic [ID_W-1:0]                 grant_id_o,
  output logic                            grant_valid_o,
  output logic                            grant_last_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                  r_state;
  logic [REQUIRE_NUM-1:0]  r_respond;
  logic [ID_W-1:0]         r_grantId;
  logic [ID_W-1:0]         r_lastOwner;
  logic [WEIGHT_W-1:0]     r_cnt;
  logic [WEIGHT_W-1:0]     r_wEff;
  logic                    r_last;

  state_t                  w_nextState;
  logic [REQUIRE_NUM-1:0]  w_nextRespond;
  logic [ID_W-1:0]         w_nextGrantId;
  logic [ID_W-1:0]         w_nextLastOwner;
  logic [WEIGHT_W-1:0]     w_nextCnt;
  logic [WEIGHT_W-1:0]     w_nextWEff;
  logic                    w_nextLast;

  logic [WEIGHT_W-1:0]     w_weights [REQUIRE_NUM];
  logic                    w_hold;
  logic                    w_continue;
  logic                    w_found;
  logic [ID_W-1:0]         w_foundIdx;
  logic [WEIGHT_W-1:0]     w_foundWEff;
  logic [WEIGHT_W-1:0]     w_cntInc;
  logic [WEIGHT_W-1:0]     w_wEffM1;

  // Split the flat weight bus into one field per requester.
  for (genvar g = 0; g < REQUIRE_NUM; g++) begin : g_weightSplit
    assign w_weights[g] = weight_i[g*WEIGHT_W +: WEIGHT_W];
  end

`ifdef WRR_HOLD_EN
  assign w_hold = hold_i;
`else
  assign w_hold = 1'b0;
`endif

  assign w_cntInc = r_cnt + 1'b1;
  assign w_wEffM1 = r_wEff - 1'b1;

  // The owner keeps the grant while it still requests and has credit left.
  assign w_continue = (r_state == GRANT) && request_i[r_lastOwner] && (r_cnt != w_wEffM1);

  // Circular search starting just after the last owner, which is checked last.
  always_comb begin
    int cand;
    logic [ID_W-1:0] candIdx;
    w_found    = 1'b0;
    w_foundIdx = '0;
    cand       = 0;
    candIdx    = '0;
    for (int off = 1; off <= REQUIRE_NUM; off++) begin
      cand = int'(r_lastOwner) + off;
      if (cand >= REQUIRE_NUM) begin
        cand = cand - REQUIRE_NUM;
      end
      candIdx = ID_W'(cand);
      if (!w_found && request_i[candIdx]) begin
        w_found    = 1'b1;
        w_foundIdx = candIdx;
      end
    end
  end

  // A zero weight still buys one cycle of grant.
  always_comb begin
    w_foundWEff = w_weights[w_foundIdx];
    if (w_foundWEff == '0) begin
      w_foundWEff = WEIGHT_W'(1);
    end
  end

  // Next-state and next-output decision: hold, continue the slot, rearbitrate or go idle.
  always_comb begin
    w_nextState     = r_state;
    w_nextRespond   = r_respond;
    w_nextGrantId   = r_grantId;
    w_nextLastOwner = r_lastOwner;
    w_nextCnt       = r_cnt;
    w_nextWEff      = r_wEff;
    w_nextLast      = r_last;
    if (w_hold) begin
      w_nextState = r_state;
    end else if (w_continue) begin
      w_nextCnt  = w_cntInc;
      w_nextLast = (w_cntInc == w_wEffM1);
    end else if (w_found) begin
      w_nextState     = GRANT;
      w_nextRespond   = '0;
      w_nextRespond[w_foundIdx] = 1'b1;
      w_nextGrantId   = w_foundIdx;
      w_nextLastOwner = w_foundIdx;
      w_nextCnt       = '0;
      w_nextWEff      = w_foundWEff;
      w_nextLast      = (w_foundWEff == WEIGHT_W'(1));
    end else begin
      w_nextState   = IDLE;
      w_nextRespond = '0;
      w_nextCnt     = '0;
      w_nextLast    = 1'b0;
    end
  end

  // State register with synchronous active-low reset that aborts any slot.
  always_ff @(posedge sys_clk_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_respond   <= '0;
      r_grantId   <= '0;
      r_lastOwner <= ID_W'(REQUIRE_NUM - 1);
      r_cnt       <= '0;
      r_wEff      <= WEIGHT_W'(1);
      r_last      <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_respond   <= w_nextRespond;
      r_grantId   <= w_nextGrantId;
      r_lastOwner <= w_nextLastOwner;
      r_cnt       <= w_nextCnt;
      r_wEff      <= w_nextWEff;
      r_last      <= w_nextLast;
    end
  end

  assign respond_o     = r_respond;
  assign grant_id_o    = r_grantId;
  assign grant_valid_o = (r_state == GRANT);
  assign grant_last_o  = r_last;

endmodule

// File: tb/tb_weighted_round_robin_arbiter.sv
// Testbench for weighted_round_robin_arbiter (REQUIRE_NUM=4, WEIGHT_W=4).
// Directed vector table followed by randomized traffic checked against a
// slot-level reference model. Hold vectors are included when WRR_HOLD_EN is set.

module tb_weighted_round_robin_arbiter;

  localparam int N  = 4;
  localparam int WW = 4;

  typedef struct {
    logic          rstN;
    logic [N-1:0]  req;
    logic [N*WW-1:0] wt;
    logic          hold;
    logic [N-1:0]  expResp;
    logic          expLast;
    int            expId;
  } vec_t;

  logic            sysClk = 1'b0;
  logic            rstN = 1'b0;
  logic [N-1:0]    request = '0;
  logic [N*WW-1:0] weight = '0;
  logic            holdIn = 1'b0;
  logic [N-1:0]    respond;
  logic [1:0]      grantId;
  logic            grantValid;
  logic            grantLast;

  int checkCount = 0;
  int errorCount = 0;

  vec_t vecs[$];

  int mValid, mOwner, mLastOwner, mUsed, mWeff, mGrantId;

  weighted_round_robin_arbiter #(.REQUIRE_NUM(N), .WEIGHT_W(WW)) dut (
    .sys_clk_i    (sysClk),
    .rst_n_i      (rstN),
    .request_i    (request),
    .weight_i     (weight),
`ifdef WRR_HOLD_EN
    .hold_i       (holdIn),
`endif
    .respond_o    (respond),
    .grant_id_o   (grantId),
    .grant_valid_o(grantValid),
    .grant_last_o (grantLast)
  );

  // Free-running clock.
  always #5 sysClk = ~sysClk;

  // Reference model: tracks owner and cycles served in its slot.
  task automatic modelStep(input logic r, input logic [N-1:0] req, input logic [N*WW-1:0] wt, input logic h);
    int c;
    int w;
    bit found;
    if (!r) begin
      mValid = 0; mGrantId = 0; mLastOwner = N - 1; mUsed = 0; mOwner = 0; mWeff = 1;
    end else if (h) begin
      mUsed = mUsed;
    end else if (mValid != 0 && req[mOwner] && mUsed < mWeff) begin
      mUsed = mUsed + 1;
    end else begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        c = (mLastOwner + k) % N;
        if (!found && req[c]) begin
          found = 1;
          w = int'((wt >> (c * WW)) & 16'hF);
          mWeff = (w == 0) ? 1 : w;
          mOwner = c; mGrantId = c; mLastOwner = c; mUsed = 1; mValid = 1;
        end
      end
      if (!found) mValid = 0;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [N-1:0] req, input logic [N*WW-1:0] wt, input logic h);
    @(negedge sysClk);
    rstN = r; request = req; weight = wt; holdIn = h;
    @(posedge sysClk);
    modelStep(r, req, wt, h);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic addVec(input logic r, input logic [N-1:0] req, input logic [N*WW-1:0] wt, input logic h,
                        input logic [N-1:0] er, input logic el, input int ei);
    vec_t v;
    v.rstN = r; v.req = req; v.wt = wt; v.hold = h; v.expResp = er; v.expLast = el; v.expId = ei;
    vecs.push_back(v);
  endtask

  initial begin
    // Full-request rotation, weights 1/2/3/4, two rounds after reset.
    addVec(0, 4'b1111, 16'h4321, 0, 4'b0000, 0, 0);
    for (int r = 0; r < 2; r++) begin
      addVec(1, 4'b1111, 16'h4321, 0, 4'b0001, 1, 0);
      addVec(1, 4'b1111, 16'h4321, 0, 4'b0010, 0, 1);
      addVec(1, 4'b1111, 16'h4321, 0, 4'b0010, 1, 1);
      addVec(1, 4'b1111, 16'h4321, 0, 4'b0100, 0, 2);
      addVec(1, 4'b1111, 16'h4321, 0, 4'b0100, 0, 2);
      addVec(1, 4'b1111, 16'h4321, 0, 4'b0100, 1, 2);
      addVec(1, 4'b1111, 16'h4321, 0, 4'b1000, 0, 3);
      addVec(1, 4'b1111, 16'h4321, 0, 4'b1000, 0, 3);
      addVec(1, 4'b1111, 16'h4321, 0, 4'b1000, 0, 3);
      addVec(1, 4'b1111, 16'h4321, 0, 4'b1000, 1, 3);
    end
    // Zero weight on requester 0 behaves as one.
    for (int r = 0; r < 2; r++) begin
      addVec(1, 4'b0011, 16'h0020, 0, 4'b0001, 1, 0);
      addVec(1, 4'b0011, 16'h0020, 0, 4'b0010, 0, 1);
      addVec(1, 4'b0011, 16'h0020, 0, 4'b0010, 1, 1);
    end
    // Idle, wake-up, reset mid-slot, restart from index 0.
    addVec(1, 4'b0000, 16'h0020, 0, 4'b0000, 0, 1);
    addVec(1, 4'b0000, 16'h0020, 0, 4'b0000, 0, 1);
    addVec(1, 4'b0010, 16'h0020, 0, 4'b0010, 0, 1);
    addVec(0, 4'b0010, 16'h0020, 0, 4'b0000, 0, 0);
    addVec(1, 4'b1111, 16'h4321, 0, 4'b0001, 1, 0);
    // Owner drops mid-slot: handover with no bubble.
    addVec(1, 4'b1001, 16'h4321, 0, 4'b1000, 0, 3);
    addVec(1, 4'b1001, 16'h4321, 0, 4'b1000, 0, 3);
    addVec(1, 4'b0001, 16'h4321, 0, 4'b0001, 1, 0);
    // Sole requester re-granted with fresh slots of 3.
    for (int r = 0; r < 2; r++) begin
      addVec(1, 4'b0100, 16'h0300, 0, 4'b0100, 0, 2);
      addVec(1, 4'b0100, 16'h0300, 0, 4'b0100, 0, 2);
      addVec(1, 4'b0100, 16'h0300, 0, 4'b0100, 1, 2);
    end
`ifdef WRR_HOLD_EN
    // Hold freezes requester 1 in its first slot cycle, then the slot completes.
    addVec(0, 4'b1111, 16'h2222, 0, 4'b0000, 0, 0);
    addVec(1, 4'b1111, 16'h2222, 0, 4'b0001, 0, 0);
    addVec(1, 4'b1111, 16'h2222, 0, 4'b0001, 1, 0);
    addVec(1, 4'b1111, 16'h2222, 0, 4'b0010, 0, 1);
    for (int k = 0; k < 5; k++) addVec(1, 4'b1111, 16'h2222, 1, 4'b0010, 0, 1);
    addVec(1, 4'b1111, 16'h2222, 0, 4'b0010, 1, 1);
    addVec(1, 4'b1111, 16'h2222, 0, 4'b0100, 0, 2);
    // Hold in idle blocks a new grant, reset overrides hold.
    addVec(1, 4'b0000, 16'h2222, 0, 4'b0000, 0, 2);
    addVec(1, 4'b0001, 16'h2222, 1, 4'b0000, 0, 2);
    addVec(1, 4'b0001, 16'h2222, 0, 4'b0001, 0, 0);
    addVec(0, 4'b0001, 16'h2222, 1, 4'b0000, 0, 0);
`endif

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rstN, vecs[i].req, vecs[i].wt, vecs[i].hold);
      checkOutput($sformatf("vec%0d respond", i), int'(respond), int'(vecs[i].expResp));
      checkOutput($sformatf("vec%0d last", i), int'(grantLast), int'(vecs[i].expLast));
      checkOutput($sformatf("vec%0d valid", i), int'(grantValid), int'(vecs[i].expResp != 0));
      checkOutput($sformatf("vec%0d id", i), int'(grantId), vecs[i].expId);
    end

    // Randomized traffic against the reference model.
    applyStimulus(0, 4'b0000, 16'h0000, 0);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic [N-1:0] rq;
      logic [N*WW-1:0] wt;
      logic r;
      logic h;
      rq = '0;
      for (int b = 0; b < N; b++) rq[b] = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0) wt = N*WW'($urandom);
      else wt = weight;
      r = ($urandom_range(0, 99) != 0);
`ifdef WRR_HOLD_EN
      h = ($urandom_range(0, 9) == 0);
`else
      h = 1'b0;
`endif
      applyStimulus(r, rq, wt, h);
      checkOutput("rand respond", int'(respond), (mValid != 0) ? (1 << mOwner) : 0);
      checkOutput("rand last", int'(grantLast), int'(mValid != 0 && mUsed == mWeff));
      checkOutput("rand valid", int'(grantValid), mValid);
      checkOutput("rand id", int'(grantId), mGrantId);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
